tl_source_inflight_tracker: RTL

//  Tracks in-flight TileLink requests by source ID between A-channel issue and D-channel completion.

---
 rtl/tl_source_inflight_tracker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/tl_source_inflight_tracker.sv
// Monitor-side tracker for in-flight TileLink source IDs on one link.
// Records the request size at A issue and presents registered size-compare
// operands for every D beat. Also reports duplicate sources, responses with no
// matching request, and a watchdog timeout. Purely passive: it never drives or
// stalls the link.
module tl_source_inflight_tracker #(
    parameter int SOURCE_BITS = 4,
    parameter int SIZE_BITS   = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic                   d_last,
    input  logic [SOURCE_BITS-1:0] d_source,
    input  logic [SIZE_BITS-1:0]   d_size,
    output logic                   chk_skip,
    output logic [SIZE_BITS-1:0]   chk_exp,
    output logic [SIZE_BITS-1:0]   chk_act,
    output logic                   err_dup_source,
    output logic                   err_unknown_resp,
    output logic                   err_timeout,
    output logic [SOURCE_BITS:0]   inflight_count
);

    localparam int DEPTH = 1 << SOURCE_BITS;

    logic [DEPTH-1:0]     inflight;
    logic [DEPTH-1:0]     inflight_nxt;
    logic [SIZE_BITS-1:0] size_tbl [DEPTH];
    logic                 a_fire;
    logic                 d_fire;
    logic                 d_done;
    logic                 a_hit;
    logic                 d_hit;
    logic [SOURCE_BITS:0] count_nxt;

    // Handshake decode and next-state bitmap: D completion clears first so a
    // same-cycle A on the same source re-allocates the entry.
    always_comb begin
        a_fire       = a_valid & a_ready;
        d_fire       = d_valid & d_ready;
        d_done       = d_fire & d_last;
        a_hit        = inflight[a_source];
        d_hit        = inflight[d_source];
        inflight_nxt = inflight;
        if (d_done) begin
            inflight_nxt[d_source] = 1'b0;
        end
        if (a_fire) begin
            inflight_nxt[a_source] = 1'b1;
        end
        count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_nxt = count_nxt + {{SOURCE_BITS{1'b0}}, inflight_nxt[i]};
        end
    end

    // Tracking table: in-flight bitmap plus the size recorded at A issue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                size_tbl[i] <= '0;
            end
        end else begin
            inflight <= inflight_nxt;
            if (a_fire) begin
                size_tbl[a_source] <= a_size;
            end
        end
    end

    // Registered checker operands and error pulses; chk_exp uses the table
    // value before this cycle's A write, so a same-source re-issue checks the old size.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chk_skip         <= 1'b1;
            chk_exp          <= '0;
            chk_act          <= '0;
            err_dup_source   <= 1'b0;
            err_unknown_resp <= 1'b0;
            inflight_count   <= '0;
        end else begin
            chk_skip         <= ~(d_fire & d_hit);
            if (d_fire) begin
                chk_exp <= size_tbl[d_source];
                chk_act <= d_size;
            end
            err_dup_source   <= a_fire & a_hit & ~(d_done & (d_source == a_source));
            err_unknown_resp <= d_fire & ~d_hit;
            inflight_count   <= count_nxt;
        end
    end

    if (TIMEOUT > 0) begin : g_wd
        localparam int WD_W = $clog2(TIMEOUT + 1);
        logic [WD_W-1:0] wd_cnt;

        // Watchdog: counts cycles with work outstanding and no completion,
        // pulses once on reaching the limit, then parks until cleared.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                wd_cnt      <= '0;
                err_timeout <= 1'b0;
            end else if ((inflight_nxt == '0) || d_done) begin
                wd_cnt      <= '0;
                err_timeout <= 1'b0;
            end else if (wd_cnt != WD_W'(TIMEOUT)) begin
                wd_cnt      <= wd_cnt + 1'b1;
                err_timeout <= (wd_cnt == WD_W'(TIMEOUT - 1));
            end else begin
                err_timeout <= 1'b0;
            end
        end
    end else begin : g_no_wd
        assign err_timeout = 1'b0;
    end

endmodule
